instruction_fetch: RTL

// - Front stage of the RISC-V core: holds the program counter, reads instruction memory and presents one instruction to the decode/control stage.
// - Drives the instruction word and its PC downstream; fetch_op_code feeds control_unit.op_code directly.
// - Accepts redirects (branch/jump/trap target) from execute and squashes younger fetched work.

---
 rtl/instruction_fetch_pkg.sv | 29 ++
 rtl/instruction_fetch_if.sv | 36 +++
 rtl/instruction_fetch_pc.sv | 35 +++
 rtl/instruction_fetch.sv | 128 ++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage.
// - fetch_state_e : fetch FSM states (wait for memory, hold for decode, flush stale
//                   request, halted on fault)
// - PC_INCREMENT  : sequential PC step in bytes
// - OPC_*         : RV base opcode values, also decoded by control_unit from
//                   fetch_op_code
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_e;

    localparam int unsigned PC_INCREMENT = 4;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch stage's external signals.
// - im_req/im_addr/im_ack/im_rdata            : instruction-memory request/response
// - redirect_en/redirect_pc                   : new PC from execute
// - fetch_valid/fetch_ready                   : handshake toward decode
// - fetch_instruction/fetch_op_code/fetch_pc  : held instruction, its opcode and PC
// - fetch_fault                               : sticky misaligned-redirect flag
// master = fetch stage, slave = memory/decode/execute side.
interface instruction_fetch_if #(
    parameter int unsigned WORDSIZE         = 64,
    parameter int unsigned INSTRUCTION_SIZE = 32
);
    logic                        im_req;
    logic [WORDSIZE-1:0]         im_addr;
    logic                        im_ack;
    logic [INSTRUCTION_SIZE-1:0] im_rdata;
    logic                        redirect_en;
    logic [WORDSIZE-1:0]         redirect_pc;
    logic                        fetch_valid;
    logic                        fetch_ready;
    logic [INSTRUCTION_SIZE-1:0] fetch_instruction;
    logic [6:0]                  fetch_op_code;
    logic [WORDSIZE-1:0]         fetch_pc;
    logic                        fetch_fault;

    modport master (
        output im_req, im_addr, fetch_valid, fetch_instruction, fetch_op_code,
               fetch_pc, fetch_fault,
        input  im_ack, im_rdata, redirect_en, redirect_pc, fetch_ready
    );

    modport slave (
        input  im_req, im_addr, fetch_valid, fetch_instruction, fetch_op_code,
               fetch_pc, fetch_fault,
        output im_ack, im_rdata, redirect_en, redirect_pc, fetch_ready
    );
endinterface

// File: rtl/instruction_fetch_pc.sv
// Program counter register.
// - clk, rst_n  : clock, asynchronous active-low reset (pc -> RESET_PC)
// - load_en     : pc <= load_value (takes priority over increment)
// - load_value  : redirect target
// - incr_en     : pc <= pc + PC_INCREMENT, wrapping modulo 2^WORDSIZE
// - pc          : current program counter
module program_counter
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned         WORDSIZE = 64,
    parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en,
    input  logic [WORDSIZE-1:0] load_value,
    input  logic                incr_en,
    output logic [WORDSIZE-1:0] pc
);

    logic [WORDSIZE-1:0] pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (load_en) begin
            pc_q <= load_value;
        end else if (incr_en) begin
            pc_q <= pc_q + WORDSIZE'(PC_INCREMENT);
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, requests instruction memory and holds one instruction
// for decode.
// - clk, rst_n : clock, asynchronous active-low reset
// - bus        : instruction_fetch_if.master (memory request/response, redirect
//                input, decode handshake, held instruction/PC/opcode, fault flag)
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned         WORDSIZE         = 64,
    parameter int unsigned         INSTRUCTION_SIZE = 32,
    parameter logic [WORDSIZE-1:0] RESET_PC         = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instruction_fetch_if.master  bus
);

    fetch_state_e                state_q, state_d;
    logic [WORDSIZE-1:0]         req_addr_q, req_addr_d;
    logic [INSTRUCTION_SIZE-1:0] instr_q, instr_d;
    logic [WORDSIZE-1:0]         fpc_q, fpc_d;
    logic                        fault_q, fault_d;

    logic                        pc_load;
    logic                        pc_incr;
    logic [WORDSIZE-1:0]         pc;
    logic                        misaligned;

    // In S_WAIT pc always equals req_addr, so a plain increment gives req_addr + 4.
    program_counter #(
        .WORDSIZE (WORDSIZE),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (pc_load),
        .load_value (bus.redirect_pc),
        .incr_en    (pc_incr),
        .pc         (pc)
    );

    assign misaligned = bus.redirect_pc[1:0] != 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_WAIT;
            req_addr_q <= RESET_PC;
            instr_q    <= '0;
            fpc_q      <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            fpc_q      <= fpc_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        fpc_d      = fpc_q;
        fault_d    = fault_q;
        pc_load    = 1'b0;
        pc_incr    = 1'b0;

        if (bus.redirect_en && state_q != S_HALT) begin
            // Redirect wins over ack and ready in the same cycle.
            if (misaligned) begin
                state_d = S_HALT;
                fault_d = 1'b1;
            end else begin
                pc_load = 1'b1;
                case (state_q)
                    S_WAIT: begin
                        if (bus.im_ack) begin
                            req_addr_d = bus.redirect_pc;
                        end else begin
                            // Keep req_addr: the outstanding request must stay stable.
                            state_d = S_FLUSH;
                        end
                    end
                    S_HOLD: begin
                        req_addr_d = bus.redirect_pc;
                        state_d    = S_WAIT;
                    end
                    default: ;
                endcase
            end
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (bus.im_ack) begin
                        instr_d = bus.im_rdata;
                        fpc_d   = req_addr_q;
                        pc_incr = 1'b1;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.fetch_ready) begin
                        req_addr_d = pc;
                        state_d    = S_WAIT;
                    end
                end
                S_FLUSH: begin
                    if (bus.im_ack) begin
                        req_addr_d = pc;
                        state_d    = S_WAIT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gated by rst_n so the request drops the moment reset asserts.
    assign bus.im_req            = rst_n && (state_q == S_WAIT || state_q == S_FLUSH);
    assign bus.im_addr           = req_addr_q;
    assign bus.fetch_valid       = state_q == S_HOLD;
    assign bus.fetch_instruction = instr_q;
    assign bus.fetch_op_code     = instr_q[6:0];
    assign bus.fetch_pc          = fpc_q;
    assign bus.fetch_fault       = fault_q;

endmodule
